// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates rename tags at issue, collects ALU/LSB results,
// forwards finished values to issue and retires one entry per cycle in program order.
module reorder_buffer #(
    parameter int ROB_SIZE   = 16,
    parameter int ROB_IDX_W  = 4,
    parameter int WORD_W     = 32,
    parameter int REG_IDX_W  = 5,
    parameter int INSTR_ID_W = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  issue_en_in,
    input  logic [INSTR_ID_W-1:0] issue_instr_id_in,
    input  logic [REG_IDX_W-1:0]  issue_rd_in,
    input  logic                  issue_is_branch_in,
    input  logic                  issue_is_store_in,
    input  logic                  issue_pred_taken_in,
    output logic [ROB_IDX_W-1:0]  rob_pos_out,
    output logic                  rob_full_out,
    input  logic [ROB_IDX_W-1:0]  query_rs1_tag_in,
    input  logic [ROB_IDX_W-1:0]  query_rs2_tag_in,
    output logic                  rs1_ready_out,
    output logic                  rs2_ready_out,
    output logic [WORD_W-1:0]     rs1_value_out,
    output logic [WORD_W-1:0]     rs2_value_out,
    input  logic                  alu_en_in,
    input  logic [ROB_IDX_W-1:0]  alu_rob_pos_in,
    input  logic [WORD_W-1:0]     alu_res_in,
    input  logic                  alu_jump_in,
    input  logic [WORD_W-1:0]     alu_target_in,
    input  logic                  lsb_en_in,
    input  logic [ROB_IDX_W-1:0]  lsb_rob_pos_in,
    input  logic [WORD_W-1:0]     lsb_res_in,
    output logic                  commit_to_regfile_en_out,
    output logic [INSTR_ID_W-1:0] commit_to_regfile_instr_id_out,
    output logic [REG_IDX_W-1:0]  commit_to_regfile_rd_out,
    output logic [ROB_IDX_W-1:0]  commit_to_regfile_rob_pos_out,
    output logic [WORD_W-1:0]     commit_to_regfile_res_out,
    output logic                  commit_store_en_out,
    output logic [ROB_IDX_W-1:0]  commit_store_rob_pos_out,
    output logic                  clear_branch_out,
    output logic [WORD_W-1:0]     branch_target_out
);

    localparam logic [ROB_IDX_W-1:0] FIRST_POS = ROB_IDX_W'(1);
    localparam logic [ROB_IDX_W-1:0] LAST_POS  = ROB_IDX_W'(ROB_SIZE - 1);

    // Position 0 means "no producer", so pointers skip it on wrap.
    function automatic logic [ROB_IDX_W-1:0] next_pos(input logic [ROB_IDX_W-1:0] p);
        if (p == LAST_POS) next_pos = FIRST_POS;
        else               next_pos = p + FIRST_POS;
    endfunction

    logic [ROB_IDX_W-1:0]  head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [ROB_SIZE-1:0]   valid_q, valid_d, ready_q, ready_d;
    logic [ROB_SIZE-1:0]   is_branch_q, is_store_q, pred_taken_q, jump_q;
    logic [INSTR_ID_W-1:0] instr_id_q [ROB_SIZE];
    logic [REG_IDX_W-1:0]  rd_q       [ROB_SIZE];
    logic [WORD_W-1:0]     res_q      [ROB_SIZE];
    logic [WORD_W-1:0]     target_q   [ROB_SIZE];

    logic                  cm_en_q, cm_en_d, st_en_q, st_en_d, clr_q, clr_d;
    logic [INSTR_ID_W-1:0] cm_id_q, cm_id_d;
    logic [REG_IDX_W-1:0]  cm_rd_q, cm_rd_d;
    logic [ROB_IDX_W-1:0]  cm_pos_q, cm_pos_d, st_pos_q, st_pos_d;
    logic [WORD_W-1:0]     cm_res_q, cm_res_d, tgt_q, tgt_d;

    logic full_s, alloc_s, commit_s, flush_s;

    function automatic logic [WORD_W:0] lookup(input logic [ROB_IDX_W-1:0] tag);
        if (tag == {ROB_IDX_W{1'b0}})                  lookup = {1'b1, {WORD_W{1'b0}}};
        else if (ready_q[tag])                         lookup = {1'b1, res_q[tag]};
        else if (alu_en_in && (alu_rob_pos_in == tag)) lookup = {1'b1, alu_res_in};
        else if (lsb_en_in && (lsb_rob_pos_in == tag)) lookup = {1'b1, lsb_res_in};
        else                                           lookup = {(WORD_W + 1){1'b0}};
    endfunction

    assign {rs1_ready_out, rs1_value_out} = lookup(query_rs1_tag_in);
    assign {rs2_ready_out, rs2_value_out} = lookup(query_rs2_tag_in);

    assign full_s       = (count_q == LAST_POS);
    assign rob_full_out = full_s;
    assign rob_pos_out  = tail_q;

    assign commit_s = valid_q[head_q] && ready_q[head_q];
    assign flush_s  = commit_s && is_branch_q[head_q] && (jump_q[head_q] != pred_taken_q[head_q]);
    assign alloc_s  = issue_en_in && !full_s && !flush_s;

    // Next-state for pointers, occupancy and per-entry status bits.
    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (commit_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = next_pos(head_q);
        end else begin
            head_d = head_q;
        end
        if (alu_en_in) ready_d[alu_rob_pos_in] = 1'b1;
        else           ready_d = ready_d;
        if (lsb_en_in) ready_d[lsb_rob_pos_in] = 1'b1;
        else           ready_d = ready_d;
        if (alloc_s) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = 1'b0;
            tail_d          = next_pos(tail_q);
        end else begin
            tail_d = tail_q;
        end
        case ({alloc_s, commit_s})
            2'b10:   count_d = count_q + FIRST_POS;
            2'b01:   count_d = count_q - FIRST_POS;
            default: count_d = count_q;
        endcase
        if (flush_s) begin
            valid_d = {ROB_SIZE{1'b0}};
            ready_d = {ROB_SIZE{1'b0}};
            head_d  = FIRST_POS;
            tail_d  = FIRST_POS;
            count_d = {ROB_IDX_W{1'b0}};
        end else begin
            count_d = count_d;
        end
    end

    // Next-state for the registered commit, store-release and redirect outputs.
    always_comb begin
        cm_en_d  = commit_s;
        st_en_d  = commit_s && is_store_q[head_q];
        clr_d    = flush_s;
        cm_id_d  = cm_id_q;
        cm_rd_d  = cm_rd_q;
        cm_pos_d = cm_pos_q;
        cm_res_d = cm_res_q;
        st_pos_d = st_pos_q;
        tgt_d    = tgt_q;
        if (commit_s) begin
            cm_id_d  = instr_id_q[head_q];
            cm_rd_d  = rd_q[head_q];
            cm_pos_d = head_q;
            cm_res_d = res_q[head_q];
        end else begin
            cm_pos_d = cm_pos_q;
        end
        if (st_en_d) st_pos_d = head_q;
        else         st_pos_d = st_pos_q;
        if (flush_s) tgt_d = target_q[head_q];
        else         tgt_d = tgt_q;
    end

    // Control state and outputs: reset first, then advance only while rdy_in is high.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q   <= FIRST_POS;
            tail_q   <= FIRST_POS;
            count_q  <= {ROB_IDX_W{1'b0}};
            valid_q  <= {ROB_SIZE{1'b0}};
            ready_q  <= {ROB_SIZE{1'b0}};
            cm_en_q  <= 1'b0;
            st_en_q  <= 1'b0;
            clr_q    <= 1'b0;
            cm_id_q  <= {INSTR_ID_W{1'b0}};
            cm_rd_q  <= {REG_IDX_W{1'b0}};
            cm_pos_q <= {ROB_IDX_W{1'b0}};
            cm_res_q <= {WORD_W{1'b0}};
            st_pos_q <= {ROB_IDX_W{1'b0}};
            tgt_q    <= {WORD_W{1'b0}};
        end else if (rdy_in) begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            cm_en_q  <= cm_en_d;
            st_en_q  <= st_en_d;
            clr_q    <= clr_d;
            cm_id_q  <= cm_id_d;
            cm_rd_q  <= cm_rd_d;
            cm_pos_q <= cm_pos_d;
            cm_res_q <= cm_res_d;
            st_pos_q <= st_pos_d;
            tgt_q    <= tgt_d;
        end
    end

    // Entry payload; validity lives in valid_q/ready_q so no reset is needed here.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (alloc_s) begin
                instr_id_q[tail_q]   <= issue_instr_id_in;
                rd_q[tail_q]         <= issue_rd_in;
                is_branch_q[tail_q]  <= issue_is_branch_in;
                is_store_q[tail_q]   <= issue_is_store_in;
                pred_taken_q[tail_q] <= issue_pred_taken_in;
                jump_q[tail_q]       <= 1'b0;
            end
            if (alu_en_in) begin
                res_q[alu_rob_pos_in]    <= alu_res_in;
                jump_q[alu_rob_pos_in]   <= alu_jump_in;
                target_q[alu_rob_pos_in] <= alu_target_in;
            end
            if (lsb_en_in) begin
                res_q[lsb_rob_pos_in] <= lsb_res_in;
            end
        end
    end

    assign commit_to_regfile_en_out       = cm_en_q;
    assign commit_to_regfile_instr_id_out = cm_id_q;
    assign commit_to_regfile_rd_out       = cm_rd_q;
    assign commit_to_regfile_rob_pos_out  = cm_pos_q;
    assign commit_to_regfile_res_out      = cm_res_q;
    assign commit_store_en_out            = st_en_q;
    assign commit_store_rob_pos_out       = st_pos_q;
    assign clear_branch_out               = clr_q;
    assign branch_target_out              = tgt_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: issue, out-of-order writeback,
// forwarding, wrap/full, mispredict flush, store release and rdy_in stalls.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        issue_en_in, issue_is_branch_in, issue_is_store_in, issue_pred_taken_in;
    logic [5:0]  issue_instr_id_in;
    logic [4:0]  issue_rd_in;
    logic [3:0]  rob_pos_out, query_rs1_tag_in, query_rs2_tag_in;
    logic        rob_full_out, rs1_ready_out, rs2_ready_out;
    logic [31:0] rs1_value_out, rs2_value_out;
    logic        alu_en_in, alu_jump_in, lsb_en_in;
    logic [3:0]  alu_rob_pos_in, lsb_rob_pos_in;
    logic [31:0] alu_res_in, alu_target_in, lsb_res_in;
    logic        commit_to_regfile_en_out, commit_store_en_out, clear_branch_out;
    logic [5:0]  commit_to_regfile_instr_id_out;
    logic [4:0]  commit_to_regfile_rd_out;
    logic [3:0]  commit_to_regfile_rob_pos_out, commit_store_rob_pos_out;
    logic [31:0] commit_to_regfile_res_out, branch_target_out;

    int vectors = 0;
    int miscompares = 0;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_en_in(issue_en_in), .issue_instr_id_in(issue_instr_id_in), .issue_rd_in(issue_rd_in),
        .issue_is_branch_in(issue_is_branch_in), .issue_is_store_in(issue_is_store_in),
        .issue_pred_taken_in(issue_pred_taken_in),
        .rob_pos_out(rob_pos_out), .rob_full_out(rob_full_out),
        .query_rs1_tag_in(query_rs1_tag_in), .query_rs2_tag_in(query_rs2_tag_in),
        .rs1_ready_out(rs1_ready_out), .rs2_ready_out(rs2_ready_out),
        .rs1_value_out(rs1_value_out), .rs2_value_out(rs2_value_out),
        .alu_en_in(alu_en_in), .alu_rob_pos_in(alu_rob_pos_in), .alu_res_in(alu_res_in),
        .alu_jump_in(alu_jump_in), .alu_target_in(alu_target_in),
        .lsb_en_in(lsb_en_in), .lsb_rob_pos_in(lsb_rob_pos_in), .lsb_res_in(lsb_res_in),
        .commit_to_regfile_en_out(commit_to_regfile_en_out),
        .commit_to_regfile_instr_id_out(commit_to_regfile_instr_id_out),
        .commit_to_regfile_rd_out(commit_to_regfile_rd_out),
        .commit_to_regfile_rob_pos_out(commit_to_regfile_rob_pos_out),
        .commit_to_regfile_res_out(commit_to_regfile_res_out),
        .commit_store_en_out(commit_store_en_out), .commit_store_rob_pos_out(commit_store_rob_pos_out),
        .clear_branch_out(clear_branch_out), .branch_target_out(branch_target_out)
    );

    always #5 clk_in = ~clk_in;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; issue_en_in = 1'b0; issue_instr_id_in = 6'd0; issue_rd_in = 5'd0;
        issue_is_branch_in = 1'b0; issue_is_store_in = 1'b0; issue_pred_taken_in = 1'b0;
        query_rs1_tag_in = 4'd0; query_rs2_tag_in = 4'd0;
        alu_en_in = 1'b0; alu_rob_pos_in = 4'd0; alu_res_in = 32'd0; alu_jump_in = 1'b0;
        alu_target_in = 32'd0; lsb_en_in = 1'b0; lsb_rob_pos_in = 4'd0; lsb_res_in = 32'd0;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    task automatic issue(input logic [5:0] id, input logic [4:0] rd,
                         input logic br, input logic st, input logic pt);
        issue_en_in = 1'b1; issue_instr_id_in = id; issue_rd_in = rd;
        issue_is_branch_in = br; issue_is_store_in = st; issue_pred_taken_in = pt;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (rob_pos_out !== 4'd1) begin miscompares++; $display("FAIL reset_pos: got %0d want 1", rob_pos_out); end
        vectors++; if (rob_full_out !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", rob_full_out); end
        vectors++; if ({commit_to_regfile_en_out, commit_store_en_out, clear_branch_out} !== 3'b000) begin
            miscompares++; $display("FAIL reset_enables: got %b want 000", {commit_to_regfile_en_out, commit_store_en_out, clear_branch_out}); end
        vectors++; if ({commit_to_regfile_res_out, branch_target_out} !== 64'd0) begin
            miscompares++; $display("FAIL reset_data: got %h want 0", {commit_to_regfile_res_out, branch_target_out}); end
    endtask

    task automatic test_in_order_commit();
        logic [31:0] exp_res [4];
        exp_res[1] = 32'h0000_1111; exp_res[2] = 32'h0000_2222; exp_res[3] = 32'h0000_3333;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            issue(6'(i + 10), 5'(i), 1'b0, 1'b0, 1'b0);
            step();
            vectors++; if (rob_pos_out !== 4'(i + 1)) begin miscompares++; $display("FAIL issue_tag%0d: got %0d want %0d", i, rob_pos_out, i + 1); end
        end
        idle();
        alu_en_in = 1'b1; alu_rob_pos_in = 4'd3; alu_res_in = exp_res[3];
        step();
        vectors++; if (commit_to_regfile_en_out !== 1'b0) begin miscompares++; $display("FAIL early_commit_a: got %b want 0", commit_to_regfile_en_out); end
        alu_rob_pos_in = 4'd1; alu_res_in = exp_res[1];
        step();
        vectors++; if (commit_to_regfile_en_out !== 1'b0) begin miscompares++; $display("FAIL early_commit_b: got %b want 0", commit_to_regfile_en_out); end
        alu_rob_pos_in = 4'd2; alu_res_in = exp_res[2];
        for (int i = 1; i <= 3; i++) begin
            step();
            alu_en_in = 1'b0;
            vectors++;
            if (commit_to_regfile_en_out !== 1'b1 || commit_to_regfile_rob_pos_out !== 4'(i) ||
                commit_to_regfile_res_out !== exp_res[i] || commit_to_regfile_rd_out !== 5'(i) ||
                commit_to_regfile_instr_id_out !== 6'(i + 10)) begin
                miscompares++;
                $display("FAIL commit_order%0d: got en=%b pos=%0d rd=%0d id=%0d res=%h want en=1 pos=%0d rd=%0d id=%0d res=%h",
                         i, commit_to_regfile_en_out, commit_to_regfile_rob_pos_out, commit_to_regfile_rd_out,
                         commit_to_regfile_instr_id_out, commit_to_regfile_res_out, i, i, i + 10, exp_res[i]);
            end
        end
        step();
        vectors++; if (commit_to_regfile_en_out !== 1'b0) begin miscompares++; $display("FAIL commit_drop: got %b want 0", commit_to_regfile_en_out); end
    endtask

    task automatic test_forwarding();
        do_reset();
        issue(6'd1, 5'd4, 1'b0, 1'b0, 1'b0); step();
        issue(6'd2, 5'd5, 1'b0, 1'b0, 1'b0); step();
        idle();
        query_rs1_tag_in = 4'd1; query_rs2_tag_in = 4'd2;
        #1;
        vectors++; if ({rs1_ready_out, rs2_ready_out} !== 2'b00) begin miscompares++; $display("FAIL fwd_not_ready: got %b want 00", {rs1_ready_out, rs2_ready_out}); end
        alu_en_in = 1'b1; alu_rob_pos_in = 4'd2; alu_res_in = 32'hDEAD_BEEF;
        query_rs1_tag_in = 4'd2; query_rs2_tag_in = 4'd0;
        #1;
        vectors++; if (rs1_ready_out !== 1'b1 || rs1_value_out !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL fwd_alu_bypass: got %b/%h want 1/deadbeef", rs1_ready_out, rs1_value_out); end
        vectors++; if (rs2_ready_out !== 1'b1 || rs2_value_out !== 32'd0) begin
            miscompares++; $display("FAIL fwd_tag0: got %b/%h want 1/00000000", rs2_ready_out, rs2_value_out); end
        step();
        alu_en_in = 1'b0;
        lsb_en_in = 1'b1; lsb_rob_pos_in = 4'd1; lsb_res_in = 32'h0000_5555;
        query_rs1_tag_in = 4'd1; query_rs2_tag_in = 4'd2;
        #1;
        vectors++; if (rs1_ready_out !== 1'b1 || rs1_value_out !== 32'h0000_5555) begin
            miscompares++; $display("FAIL fwd_lsb_bypass: got %b/%h want 1/00005555", rs1_ready_out, rs1_value_out); end
        vectors++; if (rs2_ready_out !== 1'b1 || rs2_value_out !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL fwd_stored: got %b/%h want 1/deadbeef", rs2_ready_out, rs2_value_out); end
        step();
        idle();
        step();
        vectors++; if (commit_to_regfile_res_out !== 32'h0000_5555) begin miscompares++; $display("FAIL fwd_commit1: got %h want 00005555", commit_to_regfile_res_out); end
        step();
        vectors++; if (commit_to_regfile_res_out !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL fwd_commit2: got %h want deadbeef", commit_to_regfile_res_out); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            issue(6'(i), 5'(i), 1'b0, 1'b0, 1'b0);
            step();
            if (i == 14) begin
                vectors++; if (rob_full_out !== 1'b0) begin miscompares++; $display("FAIL full_early: got %b want 0", rob_full_out); end
            end
        end
        vectors++; if (rob_full_out !== 1'b1 || rob_pos_out !== 4'd1) begin
            miscompares++; $display("FAIL full_set: got full=%b pos=%0d want full=1 pos=1", rob_full_out, rob_pos_out); end
        issue(6'd16, 5'd16, 1'b0, 1'b0, 1'b0);
        step();
        vectors++; if (rob_full_out !== 1'b1 || rob_pos_out !== 4'd1) begin
            miscompares++; $display("FAIL full_ignore: got full=%b pos=%0d want full=1 pos=1", rob_full_out, rob_pos_out); end
        idle();
        alu_en_in = 1'b1; alu_rob_pos_in = 4'd1; alu_res_in = 32'h0000_00A1;
        step();
        alu_en_in = 1'b0;
        step();
        vectors++; if (commit_to_regfile_en_out !== 1'b1 || commit_to_regfile_rob_pos_out !== 4'd1 ||
                       commit_to_regfile_instr_id_out !== 6'd1 || rob_full_out !== 1'b0) begin
            miscompares++; $display("FAIL full_commit: got en=%b pos=%0d id=%0d full=%b want en=1 pos=1 id=1 full=0",
                                    commit_to_regfile_en_out, commit_to_regfile_rob_pos_out, commit_to_regfile_instr_id_out, rob_full_out); end
        issue(6'd17, 5'd17, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        vectors++; if (rob_full_out !== 1'b1 || rob_pos_out !== 4'd2) begin
            miscompares++; $display("FAIL wrap_issue: got full=%b pos=%0d want full=1 pos=2", rob_full_out, rob_pos_out); end
    endtask

    task automatic test_mispredict();
        int stray;
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            issue(6'(i), 5'(i), (i == 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            step();
        end
        idle();
        for (int i = 1; i <= 3; i++) begin
            alu_en_in = 1'b1; alu_rob_pos_in = 4'(i); alu_res_in = 32'(i);
            lsb_en_in = 1'b1; lsb_rob_pos_in = 4'(i + 4); lsb_res_in = 32'(i + 100);
            step();
        end
        lsb_en_in = 1'b0;
        alu_rob_pos_in = 4'd4; alu_res_in = 32'h0000_0044; alu_jump_in = 1'b1; alu_target_in = 32'h0000_1000;
        step();
        idle();
        vectors++; if (commit_to_regfile_en_out !== 1'b1 || commit_to_regfile_rob_pos_out !== 4'd3 || clear_branch_out !== 1'b0) begin
            miscompares++; $display("FAIL pre_branch: got en=%b pos=%0d clr=%b want en=1 pos=3 clr=0",
                                    commit_to_regfile_en_out, commit_to_regfile_rob_pos_out, clear_branch_out); end
        step();
        vectors++; if (clear_branch_out !== 1'b1 || branch_target_out !== 32'h0000_1000 ||
                       commit_to_regfile_en_out !== 1'b1 || commit_to_regfile_rob_pos_out !== 4'd4) begin
            miscompares++; $display("FAIL flush: got clr=%b tgt=%h en=%b pos=%0d want clr=1 tgt=00001000 en=1 pos=4",
                                    clear_branch_out, branch_target_out, commit_to_regfile_en_out, commit_to_regfile_rob_pos_out); end
        vectors++; if (rob_pos_out !== 4'd1 || rob_full_out !== 1'b0) begin
            miscompares++; $display("FAIL flush_ptr: got pos=%0d full=%b want pos=1 full=0", rob_pos_out, rob_full_out); end
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (commit_to_regfile_en_out !== 1'b0 || clear_branch_out !== 1'b0) stray++;
        end
        vectors++; if (stray != 0) begin miscompares++; $display("FAIL young_commit: got %0d stray pulses want 0", stray); end
        issue(6'd9, 5'd9, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        vectors++; if (rob_pos_out !== 4'd2) begin miscompares++; $display("FAIL post_flush_tag: got %0d want 2", rob_pos_out); end
    endtask

    task automatic test_store();
        do_reset();
        issue(6'd5, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        idle();
        lsb_en_in = 1'b1; lsb_rob_pos_in = 4'd1; lsb_res_in = 32'h0000_0077;
        step();
        lsb_en_in = 1'b0;
        vectors++; if (commit_store_en_out !== 1'b0) begin miscompares++; $display("FAIL store_early: got %b want 0", commit_store_en_out); end
        step();
        vectors++; if (commit_store_en_out !== 1'b1 || commit_store_rob_pos_out !== 4'd1 || commit_to_regfile_en_out !== 1'b1) begin
            miscompares++; $display("FAIL store_release: got st=%b pos=%0d rf=%b want st=1 pos=1 rf=1",
                                    commit_store_en_out, commit_store_rob_pos_out, commit_to_regfile_en_out); end
        step();
        vectors++; if (commit_store_en_out !== 1'b0) begin miscompares++; $display("FAIL store_pulse: got %b want 0", commit_store_en_out); end
    endtask

    task automatic test_rdy_stall();
        int held_bad;
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            issue(6'(i), 5'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        idle();
        alu_en_in = 1'b1; alu_rob_pos_in = 4'd1; alu_res_in = 32'h0000_00AB;
        step();
        alu_en_in = 1'b0;
        issue(6'd15, 5'd15, 1'b0, 1'b0, 1'b0);
        step();
        vectors++; if (commit_to_regfile_en_out !== 1'b1 || commit_to_regfile_res_out !== 32'h0000_00AB ||
                       rob_pos_out !== 4'd1 || rob_full_out !== 1'b0) begin
            miscompares++; $display("FAIL issue_commit: got en=%b res=%h pos=%0d full=%b want en=1 res=000000ab pos=1 full=0",
                                    commit_to_regfile_en_out, commit_to_regfile_res_out, rob_pos_out, rob_full_out); end
        rdy_in = 1'b0;
        alu_en_in = 1'b1; alu_rob_pos_in = 4'd2; alu_res_in = 32'h0000_00CD;
        held_bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (commit_to_regfile_en_out !== 1'b1 || commit_to_regfile_rob_pos_out !== 4'd1 || rob_pos_out !== 4'd1) held_bad++;
        end
        vectors++; if (held_bad != 0) begin miscompares++; $display("FAIL rdy_hold: got %0d changed cycles want 0", held_bad); end
        idle();
        step();
        vectors++; if (commit_to_regfile_en_out !== 1'b0) begin miscompares++; $display("FAIL rdy_resume: got %b want 0", commit_to_regfile_en_out); end
        step();
        vectors++; if (commit_to_regfile_en_out !== 1'b0 || rob_pos_out !== 4'd1) begin
            miscompares++; $display("FAIL rdy_no_extra: got en=%b pos=%0d want en=0 pos=1", commit_to_regfile_en_out, rob_pos_out); end
        issue(6'd16, 5'd16, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        vectors++; if (rob_full_out !== 1'b1 || rob_pos_out !== 4'd2) begin
            miscompares++; $display("FAIL rdy_refill: got full=%b pos=%0d want full=1 pos=2", rob_full_out, rob_pos_out); end
    endtask

    initial begin
        test_reset();
        test_in_order_commit();
        test_forwarding();
        test_full_wrap();
        test_mispredict();
        test_store();
        test_rdy_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
